// File: rtl/fx_mac_feeder.sv
// fx_mac_feeder: weight bank plus ping-pong activation buffer issuing K-pair bursts to the MAC
module fx_mac_feeder #(
    parameter int WIDTH = 8,
    parameter int K = 9,
    parameter int GAP = 5,
    localparam int AW = (K > 1) ? $clog2(K) : 1
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             w_we,
    input  logic [AW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_data,
    input  logic             d_vld,
    output logic             d_rdy,
    input  logic [WIDTH-1:0] d_data,
    output logic             mac_vld_o,
    output logic [WIDTH-1:0] mac_win_o,
    output logic [WIDTH-1:0] mac_din_o,
    output logic             busy_o
);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] w_q [K];
    logic [WIDTH-1:0] bank_q [2][K];
    logic [1:0]       full_q, full_d;
    logic             fill_bank_q, rd_bank_q;
    logic [AW-1:0]    fill_idx_q, idx_q, rd_idx;
    logic [GW-1:0]    gap_cnt_q;
    logic             mac_vld_q;
    logic [WIDTH-1:0] mac_win_q, mac_din_q;
    logic             d_acc, last_beat, burst_end, gap_done, start, issue;

    assign d_rdy     = ~rst & ~full_q[fill_bank_q];
    assign d_acc     = d_vld & d_rdy;
    assign last_beat = d_acc & (fill_idx_q == AW'(K - 1));
    assign burst_end = (state_q == S_BURST) & (idx_q == AW'(K - 1));
    assign gap_done  = (state_q == S_GAP) & (gap_cnt_q == GW'(GAP - 1));
    // a burst may start from IDLE or directly at the end of the gap
    assign start     = full_q[rd_bank_q] & ((state_q == S_IDLE) | gap_done);
    assign issue     = start | ((state_q == S_BURST) & ~burst_end);
    assign rd_idx    = start ? '0 : idx_q + AW'(1);
    assign busy_o    = (|full_q) | (state_q != S_IDLE);
    assign mac_vld_o = mac_vld_q;
    assign mac_win_o = mac_win_q;
    assign mac_din_o = mac_din_q;

    // fill and drain always touch different banks, so set and clear never collide
    always_comb begin
        full_d = full_q;
        full_d[fill_bank_q] = full_q[fill_bank_q] | last_beat;
        full_d[rd_bank_q] = full_d[rd_bank_q] & ~burst_end;
    end

    // weight bank, writable only while nothing is buffered or in flight
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++) w_q[i] <= '0;
        end else if (w_we & ~busy_o & ({1'b0, w_addr} < (AW + 1)'(K))) begin
            w_q[w_addr] <= w_data;
        end
    end

    // buffer bookkeeping: fill pointer, full flags and read bank
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            full_q      <= '0;
            fill_bank_q <= 1'b0;
            fill_idx_q  <= '0;
            rd_bank_q   <= 1'b0;
        end else begin
            full_q    <= full_d;
            rd_bank_q <= rd_bank_q ^ burst_end;
            if (d_acc) begin
                fill_idx_q  <= last_beat ? '0 : fill_idx_q + AW'(1);
                fill_bank_q <= fill_bank_q ^ last_beat;
            end
        end
    end

    // activation storage needs no reset: full flags gate every read
    always_ff @(posedge clk_i) begin
        if (d_acc) bank_q[fill_bank_q][fill_idx_q] <= d_data;
    end

    // issue FSM with registered valid and data so pairs stay aligned
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            gap_cnt_q <= '0;
            mac_vld_q <= 1'b0;
            mac_win_q <= '0;
            mac_din_q <= '0;
        end else begin
            state_q   <= issue ? S_BURST : burst_end ? S_GAP : gap_done ? S_IDLE : state_q;
            gap_cnt_q <= (state_q == S_GAP) ? gap_cnt_q + GW'(1) : '0;
            mac_vld_q <= issue;
            if (issue) begin
                idx_q     <= rd_idx;
                mac_win_q <= w_q[rd_idx];
                mac_din_q <= bank_q[rd_bank_q][rd_idx];
            end
        end
    end
endmodule

// File: tb/tb_fx_mac_feeder.sv
// tb_fx_mac_feeder: randomized and directed checks of fx_mac_feeder against a window-level model
module tb_fx_mac_feeder;
    localparam int WIDTH = 8;
    localparam int K = 9;
    localparam int GAP = 5;
    localparam int AW = $clog2(K);

    logic             clk_i = 1'b0;
    logic             rst = 1'b1;
    logic             w_we = 1'b0;
    logic [AW-1:0]    w_addr = '0;
    logic [WIDTH-1:0] w_data = '0;
    logic             d_vld = 1'b0;
    logic [WIDTH-1:0] d_data = '0;
    logic             d_rdy, mac_vld_o, busy_o;
    logic [WIDTH-1:0] mac_win_o, mac_din_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run = 0;
    int low = GAP;
    int last_cyc = 0;
    int s;
    bit saw_stall;
    logic [WIDTH-1:0] w_m [K];
    logic [WIDTH-1:0] cur_q [$];
    logic [WIDTH-1:0] exp_w [$];
    logic [WIDTH-1:0] exp_d [$];
    int starts [$];

    fx_mac_feeder #(.WIDTH(WIDTH), .K(K), .GAP(GAP)) dut (
        .clk_i(clk_i), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .d_vld(d_vld), .d_rdy(d_rdy), .d_data(d_data), .mac_vld_o(mac_vld_o),
        .mac_win_o(mac_win_o), .mac_din_o(mac_din_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every valid cycle must carry the next expected pair, bursts are K long, gaps >= GAP
    always @(negedge clk_i) begin
        if (rst) begin
            run = 0;
            low = GAP;
        end else if (mac_vld_o) begin
            if (run == 0) begin
                starts.push_back(cyc);
                check("gap_len", 32'(low >= GAP), 1);
            end
            run++;
            low = 0;
            if (exp_w.size() == 0) check("spurious_vld", 1, 0);
            else begin
                check("win", 32'(mac_win_o), 32'(exp_w.pop_front()));
                check("din", 32'(mac_din_o), 32'(exp_d.pop_front()));
            end
        end else begin
            if (run != 0) check("burst_len", run, K);
            run = 0;
            low++;
        end
    end

    task automatic send_beat(input logic [WIDTH-1:0] v);
        int t = 0;
        @(negedge clk_i);
        d_vld = 1'b1;
        d_data = v;
        while (!d_rdy && t < 300) begin
            saw_stall = 1'b1;
            @(negedge clk_i);
            t++;
        end
        if (t >= 300) begin
            check("rdy_timeout", 0, 1);
            d_vld = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        last_cyc = cyc;
        cur_q.push_back(v);
        if (cur_q.size() == K) begin
            for (int i = 0; i < K; i++) begin
                exp_w.push_back(w_m[i]);
                exp_d.push_back(cur_q[i]);
            end
            cur_q.delete();
        end
    endtask

    task automatic drop();
        @(negedge clk_i);
        d_vld = 1'b0;
    endtask

    task automatic send_window(input logic [WIDTH-1:0] base, input bit rnd, input bit bubbles);
        for (int i = 0; i < K; i++) begin
            send_beat(rnd ? WIDTH'($urandom) : base + WIDTH'(i));
            if (bubbles && $urandom_range(3) == 0) drop();
        end
    endtask

    task automatic write_w(input logic [AW-1:0] a, input logic [WIDTH-1:0] v, input bit takes);
        @(negedge clk_i);
        w_we = 1'b1;
        w_addr = a;
        w_data = v;
        @(posedge clk_i);
        #1 w_we = 1'b0;
        if (takes && int'(a) < K) w_m[a] = v;
    endtask

    task automatic wait_start(output int c);
        int t = 0;
        do begin
            @(negedge clk_i);
            t++;
        end while (!mac_vld_o && t < 200);
        check("start_timeout", 32'(mac_vld_o), 1);
        c = cyc;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk_i);
            t++;
        end while ((busy_o || mac_vld_o) && t < 500);
        check("idle_timeout", 32'(busy_o | mac_vld_o), 0);
    endtask

    initial begin
        for (int i = 0; i < K; i++) w_m[i] = '0;
        #1;
        check("rst_vld", 32'(mac_vld_o), 0);
        check("rst_rdy", 32'(d_rdy), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_win", 32'(mac_win_o), 0);
        check("rst_din", 32'(mac_din_o), 0);
        repeat (3) @(negedge clk_i);
        rst = 1'b0;
        #1 check("rdy_after_rst", 32'(d_rdy), 1);

        // basic window: weights 1..9, data 0x10..0x18
        for (int i = 0; i < K; i++) write_w(AW'(i), WIDTH'(i + 1), 1'b1);
        send_window(8'h10, 1'b0, 1'b0);
        drop();
        wait_start(s);
        check("latency", s - last_cyc, 1);
        repeat (K + GAP - 1) @(negedge clk_i);
        check("busy_in_gap", 32'(busy_o), 1);
        check("vld_in_gap", 32'(mac_vld_o), 0);
        @(negedge clk_i);
        check("busy_after_gap", 32'(busy_o), 0);

        // three windows back to back with d_vld held high
        starts.delete();
        saw_stall = 1'b0;
        for (int n = 0; n < 3; n++) send_window(8'h20 + WIDTH'(n * K), 1'b0, 1'b0);
        drop();
        wait_idle();
        check("stall_seen", 32'(saw_stall), 1);
        check("burst_count", starts.size(), 3);
        if (starts.size() == 3)
            for (int i = 0; i < 2; i++) check("period", starts[i + 1] - starts[i], K + GAP);

        // weight writes during a burst and to an out-of-range address are dropped
        send_window('0, 1'b1, 1'b0);
        drop();
        wait_start(s);
        check("busy_in_burst", 32'(busy_o), 1);
        write_w('0, 8'h7F, 1'b0);
        wait_idle();
        write_w(AW'(9), 8'h55, 1'b1);
        send_window('0, 1'b1, 1'b0);
        drop();
        wait_idle();

        // partial window waits, then completes
        for (int i = 0; i < 4; i++) send_beat(WIDTH'($urandom));
        drop();
        repeat (30) @(negedge clk_i);
        check("partial_busy", 32'(busy_o), 0);
        check("partial_vld", 32'(mac_vld_o), 0);
        for (int i = 4; i < K; i++) send_beat(WIDTH'($urandom));
        drop();
        wait_start(s);
        check("partial_latency", s - last_cyc, 1);
        wait_idle();

        // asynchronous reset in the 4th burst cycle
        send_window('0, 1'b1, 1'b0);
        drop();
        wait_start(s);
        repeat (3) @(posedge clk_i);
        #2 rst = 1'b1;
        #1;
        check("arst_vld", 32'(mac_vld_o), 0);
        check("arst_rdy", 32'(d_rdy), 0);
        check("arst_busy", 32'(busy_o), 0);
        check("arst_win", 32'(mac_win_o), 0);
        exp_w.delete();
        exp_d.delete();
        cur_q.delete();
        for (int i = 0; i < K; i++) w_m[i] = '0;
        @(negedge clk_i);
        check("arst_rdy_hold", 32'(d_rdy), 0);
        repeat (2) @(negedge clk_i);
        rst = 1'b0;
        send_window('0, 1'b1, 1'b0);
        drop();
        wait_start(s);
        check("post_rst_latency", s - last_cyc, 1);
        wait_idle();

        // random weights and random windows with producer bubbles
        for (int i = 0; i < 12; i++) write_w(AW'($urandom_range(15)), WIDTH'($urandom), 1'b1);
        for (int n = 0; n < 6; n++) send_window('0, 1'b1, 1'b1);
        drop();
        wait_idle();
        check("leftover_pairs", exp_w.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fx_mac_feeder.md
# fx_mac_feeder

Sequencer that sits directly upstream of the fixed-point MAC stage. It holds a K-entry weight bank and accepts activation windows as an element stream into a ping-pong buffer. For each complete window it issues one burst of exactly K valid (weight, activation) pairs to the MAC, followed by a fixed idle gap. The gap lets the MAC round, clip, emit its result and clear its accumulator before the next burst.

## Interface
- WIDTH, 8, bitwidth of weights and activations (two's complement fixed point, passed through unmodified)
- K, 9, elements per window / multiplications per MAC result
- GAP, 5, idle cycles forced after each burst; must be ≥5 (MAC needs 5 low cycles of its valid to clear)
- AW, $clog2(K), weight address width (localparam)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- w_we  in  1  weight write strobe
- w_addr  in  AW  weight index 0..K-1
- w_data  in  WIDTH  weight value
- d_vld  in  1  activation element valid
- d_rdy  out  1  activation element ready (combinational)
- d_data  in  WIDTH  activation element; window order index 0..K-1
- mac_vld_o  out  1  MAC input valid (drives MAC vld_i)
- mac_win_o  out  WIDTH  weight to MAC
- mac_din_o  out  WIDTH  activation to MAC
- busy_o  out  1  high when any bank is full or the FSM is not IDLE

## Operation
- Weight bank: K registers, reset to 0.
  - Write when w_we & ~busy_o & w_addr<K.
  - Writes with busy_o=1 or w_addr≥K are dropped silently.
- Activation buffer: two banks of K registers, with per-bank flag full[b], a fill pointer fill_bank/fill_idx, and a read pointer rd_bank.
  - d_rdy = ~rst & ~full[fill_bank].
  - Beat accepted on d_vld & d_rdy: store to bank[fill_bank][fill_idx], fill_idx++.
  - On the accepted beat with fill_idx==K-1: set full[fill_bank], toggle fill_bank, fill_idx←0.
- Issue FSM states: IDLE, BURST, GAP.
  - IDLE: if full[rd_bank] → BURST, idx←0.
  - BURST: each cycle register mac_vld_o=1, mac_win_o=weight[idx], mac_din_o=bank[rd_bank][idx], then idx++.
    - After driving idx=K-1: clear full[rd_bank], toggle rd_bank, gap_cnt←0 → GAP.
  - GAP: mac_vld_o=0; gap_cnt++. After GAP cycles, go to BURST if full[rd_bank] (idx←0), else IDLE.
- Simultaneous events:
  - Filling and reading always target different banks, so a set of full[] and a clear of full[] in the same cycle touch distinct bits and both take effect.
  - A bank freed in cycle n is writable (d_rdy=1) from cycle n+1.
- Partial windows (fewer than K beats) wait indefinitely; no burst is issued.
- Outside BURST, mac_win_o/mac_din_o hold their last values and are don't-care.
- Reset (any time, including mid-burst or mid-fill) forces:
  - full=00, fill_idx=0, fill_bank=0, rd_bank=0, FSM=IDLE, weights=0.
  - Partial and buffered windows are discarded.
  - Outputs: mac_vld_o=0, mac_win_o=0, mac_din_o=0, busy_o=0, d_rdy=0 while rst is high.

## Timing
- Last beat of a window accepted at edge E with FSM in IDLE:
  - full visible after E; FSM enters BURST at E+1.
  - mac_vld_o is high for cycles E+1..E+K (exactly K consecutive cycles), then low for exactly GAP cycles.
- Steady-state period with the producer ahead: K+GAP cycles per window (14 at defaults). mac_vld_o never pulses for fewer or more than K cycles.
- Producer throughput: up to 2 windows buffered. d_rdy drops the cycle after both banks are full and rises the cycle after the active burst's last element.
- Data and valid are registered together, so pairs are aligned with mac_vld_o in the same cycle.

## Test plan
- Load w[i]=i+1 (i=0..8) with busy_o=0, stream d[i]=0x10+i back-to-back. Required: mac_vld_o high 9 cycles starting 1 cycle after the last beat, carrying win 1..9 and din 0x10..0x18 in order, then low 5 cycles; busy_o falls after the gap.
- Stream 3 windows continuously with d_vld held high. Required: d_rdy deasserts while both banks are full; bursts are separated by exactly 5 low cycles; window data is never mixed between banks; all 27 pairs appear in order.
- Attempt a weight write (w_addr=0, w_data=0x7F) during a burst. Required: write dropped; the next burst still carries w[0]=1. A write to w_addr=9 is also dropped.
- Send 4 beats of a window and stop. Required: no mac_vld_o and busy_o=0. Then send the remaining 5 beats. Required: one 9-cycle burst.
- Assert rst asynchronously in the 4th burst cycle. Required: mac_vld_o=0 immediately, d_rdy=0 while rst is high, and weights read 0 after release. A fresh window after release gives a full 9-cycle burst with win=0.
- Drive the MAC with this block at defaults and Q4.4 weights/activations of all 0x10 (1.0). Required: MAC emits 0x7F saturated (9.0 exceeds range) once per window, and the MAC accumulator clears between windows.
